// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, ALU control values, PC source
// select values, and the bundle of decoded control signals.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic [2:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one write port, register 0 hardwired to zero.
// Define DECODE_REGFILE_BYPASS_EN to make reads see a same-cycle write (write-through).
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

`ifdef DECODE_REGFILE_BYPASS_EN
  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];
`else
  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: register file, main/ALU decoders, early branch/jump resolution, ID/EX register.
// Define DECODE_REGFILE_BYPASS_EN for write-through register file reads.
module decode_stage_pipe
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int INSTR_WIDTH    = 32,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [INSTR_WIDTH-1:0]    InstrD,
  input  logic [31:0]               PCPlus4D,
  input  logic                      RegWriteW,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegW,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  input  logic                      RegWriteM,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegM,
  input  logic [DATA_WIDTH-1:0]     ALUOutM,
  input  logic                      StallE,
  input  logic                      FlushE,
  output logic [REG_ADDR_WIDTH-1:0] RsD,
  output logic [REG_ADDR_WIDTH-1:0] RtD,
  output logic                      BranchD,
  output logic                      JumpD,
  output logic [1:0]                PCSrcD,
  output logic [31:0]               PCBranchD,
  output logic [31:0]               PCJumpD,
  output logic                      RegWriteE,
  output logic                      MemtoRegE,
  output logic                      MemWriteE,
  output logic                      ALUSrcE,
  output logic                      RegDstE,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     SignImmE,
  output logic [REG_ADDR_WIDTH-1:0] RsE,
  output logic [REG_ADDR_WIDTH-1:0] RtE,
  output logic [REG_ADDR_WIDTH-1:0] RdE
);

  logic [5:0]                op;
  logic [5:0]                funct;
  logic [REG_ADDR_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0]     sign_imm;
  logic [31:0]               branch_offset;
  logic [DATA_WIDTH-1:0]     rf_rd1;
  logic [DATA_WIDTH-1:0]     rf_rd2;
  logic [DATA_WIDTH-1:0]     cmp_a;
  logic [DATA_WIDTH-1:0]     cmp_b;
  logic                      equal_d;
  ctrl_t                     ctrl;

  assign op       = InstrD[31:26];
  assign funct    = InstrD[5:0];
  assign RsD      = REG_ADDR_WIDTH'(InstrD[25:21]);
  assign RtD      = REG_ADDR_WIDTH'(InstrD[20:16]);
  assign rd_d     = REG_ADDR_WIDTH'(InstrD[15:11]);
  assign sign_imm = {{(DATA_WIDTH-16){InstrD[15]}}, InstrD[15:0]};

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_reg_file (
    .clk (CLK),
    .rst (RST),
    .we  (RegWriteW),
    .wa  (WriteRegW),
    .wd  (ResultW),
    .ra1 (RsD),
    .ra2 (RtD),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  // Main and ALU decode; an R-type with an unsupported funct is treated as a NOP,
  // which makes the all-zero instruction a true bubble.
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_control = ALU_ADD;
          FN_SUB:  ctrl.alu_control = ALU_SUB;
          FN_AND:  ctrl.alu_control = ALU_AND;
          FN_OR:   ctrl.alu_control = ALU_OR;
          FN_SLT:  ctrl.alu_control = ALU_SLT;
          default: ctrl = '0;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_J: ctrl.jump = 1'b1;
      default: ;
    endcase
  end

  assign BranchD = ctrl.branch;
  assign JumpD   = ctrl.jump;

  // Branch operands take the M-stage ALU result when it targets the same register.
  assign cmp_a   = (RegWriteM && WriteRegM != '0 && WriteRegM == RsD) ? ALUOutM : rf_rd1;
  assign cmp_b   = (RegWriteM && WriteRegM != '0 && WriteRegM == RtD) ? ALUOutM : rf_rd2;
  assign equal_d = (cmp_a == cmp_b);

  always_comb begin
    PCSrcD = PCSRC_PLUS4;
    if (ctrl.jump) begin
      PCSrcD = PCSRC_JUMP;
    end else if (ctrl.branch && equal_d) begin
      PCSrcD = PCSRC_BRANCH;
    end
  end

  assign branch_offset = {{14{InstrD[15]}}, InstrD[15:0], 2'b00};
  assign PCBranchD     = PCPlus4D + branch_offset;
  assign PCJumpD       = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

  // ID/EX register: reset and flush both insert a bubble, flush beats stall.
  always_ff @(posedge CLK) begin
    if (RST || FlushE) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      SignImmE    <= '0;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
    end else if (!StallE) begin
      RegWriteE   <= ctrl.reg_write;
      MemtoRegE   <= ctrl.mem_to_reg;
      MemWriteE   <= ctrl.mem_write;
      ALUSrcE     <= ctrl.alu_src;
      RegDstE     <= ctrl.reg_dst;
      ALUControlE <= ALU_CTRL_WIDTH'(ctrl.alu_control);
      RD1E        <= rf_rd1;
      RD2E        <= rf_rd2;
      SignImmE    <= sign_imm;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= rd_d;
    end
  end

endmodule
